// File: rtl/cmac_bp_monitor_capture.sv
// Backpressure episode capture for the CMAC RX AXI-Stream: measures each valid-without-ready
// run, timestamps its start, tracks alignment, and queues the result in a show-ahead FIFO.
module cmac_bp_monitor_capture #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        axis_tvalid,
   input  logic        axis_tready,
   input  logic        rx_aligned,
   output logic        bp_valid,
   output logic [31:0] bp_length,
   output logic        bp_rxad,
   output logic [63:0] bp_timestamp,
   input  logic        bp_next,
   output logic [15:0] bp_dropped
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [63:0]   ts_q;
   logic [63:0]   ts_start_q, ts_start_d;
   logic [31:0]   len_q, len_d;
   logic          aligned_q, aligned_d;
   logic          push;

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [15:0]   dropped_q;
   logic          fifo_empty, fifo_full;
   logic          pop, push_ok, push_drop;
   logic [AW-1:0] wr_idx, rd_idx;

   logic [63:0]   mem_ts   [DEPTH];
   logic [31:0]   mem_len  [DEPTH];
   logic          mem_rxad [DEPTH];

   logic          bp_cycle;

   assign bp_cycle = axis_tvalid & ~axis_tready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ts_q <= 64'd0;
      end else begin
         ts_q <= ts_q + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         ts_start_q <= 64'd0;
         len_q      <= 32'd0;
         aligned_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ts_start_q <= ts_start_d;
         len_q      <= len_d;
         aligned_q  <= aligned_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ts_start_d = ts_start_q;
      len_d      = len_q;
      aligned_d  = aligned_q;
      push       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bp_cycle) begin
               state_d    = ST_ACTIVE;
               ts_start_d = ts_q;
               len_d      = 32'd1;
               aligned_d  = rx_aligned;
            end
         end
         ST_ACTIVE: begin
            if (bp_cycle) begin
               len_d     = (len_q == 32'hFFFF_FFFF) ? len_q : len_q + 32'd1;
               aligned_d = aligned_q & rx_aligned;
            end else begin
               // End cycle: the record already holds the final values and is not extended.
               push    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign wr_idx     = wr_ptr_q[AW-1:0];
   assign rd_idx     = rd_ptr_q[AW-1:0];
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
   assign pop        = bp_next & ~fifo_empty;
   // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
   assign push_ok    = push & (~fifo_full | pop);
   assign push_drop  = push & ~push_ok;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         dropped_q <= 16'd0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (push_drop && (dropped_q != 16'hFFFF)) begin
            dropped_q <= dropped_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_ts[wr_idx]   <= ts_start_q;
         mem_len[wr_idx]  <= len_q;
         mem_rxad[wr_idx] <= aligned_q;
      end
   end

   // Storage is never cleared, so the head is masked to zero while the FIFO is empty.
   assign bp_valid     = ~fifo_empty;
   assign bp_length    = fifo_empty ? 32'd0 : mem_len[rd_idx];
   assign bp_rxad      = fifo_empty ? 1'b0  : mem_rxad[rd_idx];
   assign bp_timestamp = fifo_empty ? 64'd0 : mem_ts[rd_idx];
   assign bp_dropped   = dropped_q;

endmodule

// File: tb/tb_cmac_bp_monitor_capture.sv
// Directed bench for cmac_bp_monitor_capture with a 4-entry FIFO.
module tb_cmac_bp_monitor_capture;

   logic        clk;
   logic        resetn;
   logic        axis_tvalid;
   logic        axis_tready;
   logic        rx_aligned;
   logic        bp_valid;
   logic [31:0] bp_length;
   logic        bp_rxad;
   logic [63:0] bp_timestamp;
   logic        bp_next;
   logic [15:0] bp_dropped;

   int total;
   int bad;
   longint unsigned cyc;

   cmac_bp_monitor_capture #(.DEPTH(4)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .axis_tvalid  (axis_tvalid),
      .axis_tready  (axis_tready),
      .rx_aligned   (rx_aligned),
      .bp_valid     (bp_valid),
      .bp_length    (bp_length),
      .bp_rxad      (bp_rxad),
      .bp_timestamp (bp_timestamp),
      .bp_next      (bp_next),
      .bp_dropped   (bp_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected timestamp of the cycle currently being driven (0 in the first cycle after release).
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic drive(input logic v, input logic r, input logic al, input logic nx);
      axis_tvalid = v;
      axis_tready = r;
      rx_aligned  = al;
      bp_next     = nx;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      axis_tvalid = 1'b0;
      axis_tready = 1'b0;
      rx_aligned  = 1'b1;
      bp_next     = 1'b0;
      repeat (3) begin
         @(posedge clk);
      end
      #1;
      resetn = 1'b1;
   endtask

   task automatic pop_print();
      $display("pop len=%0d ts=%0d rxad=%0b", bp_length, bp_timestamp, bp_rxad);
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      bp_next = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bp_valid); end
      total++; if (bp_dropped !== 16'd0) begin bad++; $display("FAIL reset_dropped got=%0d want=0", bp_dropped); end
      total++; if (bp_length !== 32'd0) begin bad++; $display("FAIL reset_length got=%0d want=0", bp_length); end
      total++; if (bp_timestamp !== 64'd0) begin bad++; $display("FAIL reset_ts got=%0d want=0", bp_timestamp); end
      total++; if (bp_rxad !== 1'b0) begin bad++; $display("FAIL reset_rxad got=%0b want=0", bp_rxad); end
      $display("reset done");
   endtask

   task automatic test_single();
      do_reset();
      for (int i = 0; i < 200 && cyc < 100; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (cyc != 100) begin bad++; $display("FAIL single_ts_wait got=%0d want=100", cyc); end
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
      total++; if (bp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b want=0", bp_valid); end
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (bp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", bp_valid); end
      total++; if (bp_length !== 32'd5) begin bad++; $display("FAIL single_length got=%0d want=5", bp_length); end
      total++; if (bp_timestamp !== 64'd100) begin bad++; $display("FAIL single_ts got=%0d want=100", bp_timestamp); end
      total++; if (bp_rxad !== 1'b1) begin bad++; $display("FAIL single_rxad got=%0b want=1", bp_rxad); end
      pop_print();
      total++; if (bp_valid !== 1'b0) begin bad++; $display("FAIL single_after_pop got=%0b want=0", bp_valid); end
   endtask

   task automatic test_align_drop();
      longint unsigned t0;
      t0 = cyc;
      for (int i = 1; i <= 10; i++) drive(1'b1, 1'b0, (i == 7) ? 1'b0 : 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      total++; if (bp_length !== 32'd10) begin bad++; $display("FAIL align_length got=%0d want=10", bp_length); end
      total++; if (bp_rxad !== 1'b0) begin bad++; $display("FAIL align_rxad got=%0b want=0", bp_rxad); end
      total++; if (bp_timestamp !== t0) begin bad++; $display("FAIL align_ts got=%0d want=%0d", bp_timestamp, t0); end
      pop_print();
   endtask

   task automatic test_back_to_back();
      longint unsigned t0;
      t0 = cyc;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      total++; if (bp_length !== 32'd3) begin bad++; $display("FAIL b2b_len1 got=%0d want=3", bp_length); end
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (bp_timestamp !== t0) begin bad++; $display("FAIL b2b_ts1 got=%0d want=%0d", bp_timestamp, t0); end
      pop_print();
      total++; if (bp_length !== 32'd4) begin bad++; $display("FAIL b2b_len2 got=%0d want=4", bp_length); end
      total++; if (bp_timestamp !== t0 + 4) begin bad++; $display("FAIL b2b_ts2 got=%0d want=%0d", bp_timestamp, t0 + 4); end
      pop_print();
      total++; if (bp_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b want=0", bp_valid); end
   endtask

   task automatic test_full();
      longint unsigned st [6];
      do_reset();
      for (int e = 0; e < 6; e++) begin
         st[e] = cyc;
         drive(1'b1, 1'b0, 1'b1, 1'b0);
         drive(1'b0, 1'b0, 1'b1, 1'b0);
      end
      total++; if (bp_dropped !== 16'd2) begin bad++; $display("FAIL full_dropped got=%0d want=2", bp_dropped); end
      for (int e = 0; e < 4; e++) begin
         total++; if (bp_valid !== 1'b1 || bp_timestamp !== st[e] || bp_length !== 32'd1) begin
            bad++; $display("FAIL full_order%0d got=v%0b ts%0d len%0d want=v1 ts%0d len1", e, bp_valid, bp_timestamp, bp_length, st[e]);
         end
         pop_print();
      end
      total++; if (bp_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%0b want=0", bp_valid); end
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      bp_next = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (bp_valid !== 1'b0 || bp_length !== 32'd0 || bp_dropped !== 16'd2) begin
         bad++; $display("FAIL empty_pop got=v%0b len%0d drop%0d want=v0 len0 drop2", bp_valid, bp_length, bp_dropped);
      end
      // The empty pop must not have moved pointers: one new record should be the head.
      st[0] = cyc;
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (bp_valid !== 1'b1 || bp_timestamp !== st[0]) begin
         bad++; $display("FAIL empty_pop_ptr got=v%0b ts%0d want=v1 ts%0d", bp_valid, bp_timestamp, st[0]);
      end
   endtask

   task automatic test_push_pop_full();
      longint unsigned st [5];
      do_reset();
      for (int e = 0; e < 5; e++) begin
         st[e] = cyc;
         for (int k = 0; k <= e; k++) drive(1'b1, 1'b0, 1'b1, 1'b0);
         drive(1'b0, 1'b0, 1'b1, (e == 4) ? 1'b1 : 1'b0);
      end
      bp_next = 1'b0;
      total++; if (bp_dropped !== 16'd0) begin bad++; $display("FAIL simul_dropped got=%0d want=0", bp_dropped); end
      for (int e = 1; e < 5; e++) begin
         total++; if (bp_valid !== 1'b1 || bp_length !== 32'(e + 1) || bp_timestamp !== st[e]) begin
            bad++; $display("FAIL simul_rec%0d got=v%0b len%0d ts%0d want=v1 len%0d ts%0d", e + 1, bp_valid, bp_length, bp_timestamp, e + 1, st[e]);
         end
         pop_print();
      end
      total++; if (bp_valid !== 1'b0) begin bad++; $display("FAIL simul_empty got=%0b want=0", bp_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int e = 0; e < 2; e++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0);
         drive(1'b0, 1'b0, 1'b1, 1'b0);
      end
      total++; if (bp_valid !== 1'b1) begin bad++; $display("FAIL mid_queued got=%0b want=1", bp_valid); end
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      total++; if (bp_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%0b want=0", bp_valid); end
      repeat (2) begin
         @(posedge clk);
      end
      #1;
      resetn = 1'b1;
      axis_tvalid = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (bp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_partial got=%0b want=0", bp_valid); end
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (bp_timestamp !== 64'd0 || bp_length !== 32'd2) begin
         bad++; $display("FAIL mid_ts_restart got=ts%0d len%0d want=ts0 len2", bp_timestamp, bp_length);
      end
      pop_print();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_align_drop();
      test_back_to_back();
      test_full();
      test_push_pop_full();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cmac_bp_monitor_capture.md
# cmac_bp_monitor_capture

Producer side of the CMAC backpressure monitor. Watches the valid/ready handshake of the CMAC RX AXI-Stream, detects each backpressure episode, measures its length, timestamps its start and records whether RX alignment held throughout. Each completed episode is queued in an internal show-ahead FIFO. The monitor's AXI4-Lite control block reads the head record and pops it with `bp_next`; that block's `resetn_out` drives this block's `resetn`.

## Interface
- `DEPTH`, 16: number of FIFO entries; a power of 2, minimum 2.
- `clk` in 1: the single clock for the block.
- `resetn` in 1: reset; asynchronous, active-low.
- `axis_tvalid` in 1: monitored stream TVALID (observe only).
- `axis_tready` in 1: monitored stream TREADY (observe only).
- `rx_aligned` in 1: CMAC `stat_rx_aligned`, already synchronous to `clk`.
- `bp_valid` out 1: the FIFO is non-empty and the head record is valid.
- `bp_length` out 32: head record length, in cycles of backpressure.
- `bp_rxad` out 1: head record flag; 1 means `rx_aligned` was high on every cycle of the episode.
- `bp_timestamp` out 64: head record start time.
- `bp_next` in 1: single-cycle pulse that pops the head record.
- `bp_dropped` out 16: count of episodes lost because the FIFO was full; saturates at 0xFFFF.

## Operation
- A backpressure cycle (BP cycle) is any cycle in which `axis_tvalid`=1 and `axis_tready`=0.
- Free-running 64-bit timestamp counter `ts`:
  - It is 0 in the first cycle after reset release.
  - It increments by 1 every cycle and wraps from 2^64-1 to 0.
- Episode FSM, states IDLE and ACTIVE:
  - IDLE → ACTIVE on a BP cycle.
    - Latch `ts_start` = `ts` of that cycle.
    - Set `len` = 1.
    - Set `aligned` = `rx_aligned`.
  - ACTIVE, BP cycle:
    - `len` increments, saturating at 0xFFFFFFFF.
    - `aligned` is ANDed with `rx_aligned`.
  - ACTIVE, non-BP cycle (the end cycle):
    - Push {`ts_start`, `len`, `aligned`} into the FIFO.
    - Return to IDLE.
    - The end cycle itself is never counted.
  - Two BP runs separated by exactly one non-BP cycle are two separate episodes. A new episode can start on the cycle immediately after the end cycle.
- FIFO behaviour:
  - The FIFO is show-ahead: `bp_valid` = not empty, and the `bp_*` outputs always present the head entry.
  - Pointers are ⌈log2 DEPTH⌉+1 bits wide; full/empty come from the MSB comparison; pointers wrap naturally.
  - A pop occurs when `bp_next`=1 and `bp_valid`=1.
  - `bp_next` while the FIFO is empty is ignored. It has no effect on pointers and no side effect.
  - A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the push is discarded and `bp_dropped` increments, saturating.
  - When a push and a pop coincide, occupancy is unchanged and the head advances.
- Record contents are captured at the end cycle. Later `rx_aligned` changes do not alter queued records.

## Timing
- Values after reset:
  - `bp_valid`=0; `bp_dropped`=0; `ts`=0; FSM is in IDLE.
  - `bp_length`, `bp_rxad` and `bp_timestamp` are 0, because FIFO storage is not reset but the output mux presents zeros when empty.
- Asserting reset mid-episode discards the episode in progress and all queued records.
- Push latency: if the end cycle is cycle N and the FIFO was empty, `bp_valid`=1 in cycle N+1 with the record on the `bp_*` outputs.
- Pop latency: if `bp_next` is sampled in cycle M, the next head, or `bp_valid`=0, appears in cycle M+1.
- `bp_dropped` updates in the cycle after the discarded push.
- Throughput: one push and one pop per cycle.

## Test plan
- Single episode: reset, then 5 BP cycles starting when `ts`=100, with `rx_aligned`=1 throughout → `bp_valid`=1 with `bp_length`=5, `bp_timestamp`=100, `bp_rxad`=1. After one `bp_next` pulse → `bp_valid`=0.
- Alignment drop: a 10-cycle episode with `rx_aligned`=0 on its 7th cycle only → `bp_length`=10, `bp_rxad`=0.
- Back-to-back episodes: BP for 3 cycles, 1 idle cycle, BP for 4 cycles → two records with lengths 3 and 4, and timestamps differing by 4.
- Full FIFO with `DEPTH`=4: produce 6 one-cycle episodes and never pop → 4 records queued, `bp_dropped`=2. Popping all 4 returns them in order, then `bp_valid`=0. A further `bp_next` with the FIFO empty changes nothing.
- Simultaneous push and pop while full: `bp_next` asserted on the end cycle of a 5th episode → no drop, and `bp_dropped` stays 0. Remaining records are 2, 3, 4, 5.
- Reset mid-episode: assert `resetn`=0 during cycle 3 of an episode while 2 records are queued → `bp_valid` drops to 0 without waiting for a clock edge. After release, `ts` restarts at 0 and no partial record appears.
